// File: rtl/lc3_mem_pkg.sv
// Shared constants and types for the LC-3 memory system.
// Holds the MMIO address map, the access FSM states and the decode selects.
package lc3_mem_pkg;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;
  localparam logic [15:0] MCR_ADDR  = 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } mem_state_t;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_KBSR,
    SEL_KBDR,
    SEL_DSR,
    SEL_DDR,
    SEL_MCR,
    SEL_NONE
  } sel_t;

endpackage

// File: rtl/lc3_mmio_regs.sv
// LC-3 memory-mapped device registers: keyboard, display and MCR.
// Strobes arrive from the access FSM on the commit edge only.
module lc3_mmio_regs
  import lc3_mem_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic              wr_en,
  input  sel_t              sel,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic              kb_ready,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              disp_ready,
  output logic              mcr_run
);

  logic              kbsr;
  logic              dsr;
  logic [7:0]        kbdr;
  logic [DATA_W-1:0] mcr;

  assign kb_ready = ~kbsr;
  assign mcr_run  = mcr[15];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbsr       <= 1'b0;
      kbdr       <= '0;
      dsr        <= 1'b1;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      mcr        <= DATA_W'(16'h8000);
    end else begin
      // a KBDR read beats a simultaneous keystroke
      if (rd_en && sel == SEL_KBDR) begin
        kbsr <= 1'b0;
      end else if (kb_valid && !kbsr) begin
        kbsr <= 1'b1;
        kbdr <= kb_data;
      end
      if (wr_en && sel == SEL_DDR && dsr) begin
        disp_data  <= wdata[7:0];
        disp_valid <= 1'b1;
        dsr        <= 1'b0;
      end else if (disp_valid && disp_ready) begin
        disp_valid <= 1'b0;
        dsr        <= 1'b1;
      end
      if (wr_en && sel == SEL_MCR) begin
        mcr <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      SEL_KBSR: rdata[15]  = kbsr;
      SEL_KBDR: rdata[7:0] = kbdr;
      SEL_DSR:  rdata[15]  = dsr;
      SEL_DDR:  rdata[7:0] = disp_data;
      SEL_MCR:  rdata      = mcr;
      default:  ;
    endcase
  end

endmodule

// File: rtl/lc3_mem_sys.sv
// Word-addressed LC-3 memory with wait states and MMIO decode.
// One access in flight; it commits on the edge that enters DONE.
module lc3_mem_sys
  import lc3_mem_pkg::*;
#(
  parameter int    ADDR_W      = 16,
  parameter int    DATA_W      = 16,
  parameter int    DEPTH       = 65024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_en,
  input  logic              memwe,
  input  logic [ADDR_W-1:0] mar,
  input  logic [DATA_W-1:0] mdr,
  output logic [DATA_W-1:0] memOut,
  output logic              mem_r,
  input  logic              kb_valid,
  input  logic [7:0]        kb_data,
  output logic              kb_ready,
  output logic              disp_valid,
  output logic [7:0]        disp_data,
  input  logic              disp_ready,
  output logic              mcr_run
);

  localparam int              RAM_AW  = $clog2(DEPTH);
  localparam logic [ADDR_W:0] RAM_TOP = (ADDR_W+1)'(DEPTH);

  mem_state_t        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              we_q;

  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;
  logic              acc_we;
  logic              go_done;
  sel_t              sel;
  logic [DATA_W-1:0] ram_rd;
  logic [DATA_W-1:0] mmio_rd;

  logic [DATA_W-1:0] ram [DEPTH];

  // zero-wait accesses commit straight from the request inputs
  always_comb begin
    acc_addr = (state == IDLE) ? mar    : addr_q;
    acc_data = (state == IDLE) ? mdr    : data_q;
    acc_we   = (state == IDLE) ? memwe  : we_q;
    go_done  = reset &&
               ((state == IDLE && mem_en && WAIT_CYCLES == 0) ||
                (state == WAIT && cnt == 4'd0));
    ram_rd   = ram[acc_addr[RAM_AW-1:0]];
    sel      = SEL_NONE;
    unique case (1'b1)
      ({1'b0, acc_addr} < RAM_TOP):          sel = SEL_RAM;
      (acc_addr == ADDR_W'(KBSR_ADDR)):      sel = SEL_KBSR;
      (acc_addr == ADDR_W'(KBDR_ADDR)):      sel = SEL_KBDR;
      (acc_addr == ADDR_W'(DSR_ADDR)):       sel = SEL_DSR;
      (acc_addr == ADDR_W'(DDR_ADDR)):       sel = SEL_DDR;
      (acc_addr == ADDR_W'(MCR_ADDR)):       sel = SEL_MCR;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (go_done && acc_we && sel == SEL_RAM) begin
      ram[acc_addr[RAM_AW-1:0]] <= acc_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      we_q   <= 1'b0;
      mem_r  <= 1'b0;
      memOut <= '0;
    end else begin
      mem_r <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_en) begin
            addr_q <= mar;
            data_q <= mdr;
            we_q   <= memwe;
            if (WAIT_CYCLES == 0) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= 4'(WAIT_CYCLES - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (go_done) begin
        mem_r <= 1'b1;
        if (!acc_we) begin
          memOut <= (sel == SEL_RAM) ? ram_rd : mmio_rd;
        end
      end
    end
  end

  lc3_mmio_regs #(
    .DATA_W(DATA_W)
  ) u_mmio (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (go_done & ~acc_we),
    .wr_en      (go_done & acc_we),
    .sel        (sel),
    .wdata      (acc_data),
    .rdata      (mmio_rd),
    .kb_valid   (kb_valid),
    .kb_data    (kb_data),
    .kb_ready   (kb_ready),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready),
    .mcr_run    (mcr_run)
  );

endmodule

// File: tb/tb_lc3_mem_sys.sv
// Scoreboard bench for lc3_mem_sys: a zero-wait and a three-wait instance.
// Requests push expectations; a negedge monitor pops them on mem_r.
module tb_lc3_mem_sys;
  import lc3_mem_pkg::*;

  typedef struct {
    bit          rd;
    logic [15:0] exp;
    int          lat;
    int          issue;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  mem_en = '0;
  logic [1:0]  memwe = '0;
  logic [15:0] mar [2];
  logic [15:0] mdr [2];
  logic [15:0] memOut [2];
  logic [1:0]  mem_r;
  logic [1:0]  kb_valid = '0;
  logic [7:0]  kb_data [2];
  logic [1:0]  kb_ready;
  logic [1:0]  disp_valid;
  logic [7:0]  disp_data [2];
  logic [1:0]  disp_ready = '0;
  logic [1:0]  mcr_run;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   vectors = 0;
  int   misc = 0;
  int   done_cnt [2] = '{0, 0};
  int   pend [2] = '{0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lc3_mem_sys #(.WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset(reset), .mem_en(mem_en[0]), .memwe(memwe[0]),
    .mar(mar[0]), .mdr(mdr[0]), .memOut(memOut[0]), .mem_r(mem_r[0]),
    .kb_valid(kb_valid[0]), .kb_data(kb_data[0]), .kb_ready(kb_ready[0]),
    .disp_valid(disp_valid[0]), .disp_data(disp_data[0]),
    .disp_ready(disp_ready[0]), .mcr_run(mcr_run[0])
  );

  lc3_mem_sys #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .reset(reset), .mem_en(mem_en[1]), .memwe(memwe[1]),
    .mar(mar[1]), .mdr(mdr[1]), .memOut(memOut[1]), .mem_r(mem_r[1]),
    .kb_valid(kb_valid[1]), .kb_data(kb_data[1]), .kb_ready(kb_ready[1]),
    .disp_valid(disp_valid[1]), .disp_data(disp_data[1]),
    .disp_ready(disp_ready[1]), .mcr_run(mcr_run[1])
  );

  task automatic chk(input string name, input logic [15:0] act,
                     input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    if (mem_r[d] === 1'b1) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        vectors++;
        misc++;
        $display("FAIL unexpected_mem_r dut%0d: got mem_r=1, want 0", d);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk({e.name, "_lat"}, 16'(cyc - e.issue), 16'(e.lat));
        if (e.rd) chk(e.name, memOut[d], e.exp);
        done_cnt[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic issue(input int d, input bit we, input logic [15:0] a,
                       input logic [15:0] wd, input logic [15:0] exp,
                       input bit push, input string name);
    exp_t e;
    @(negedge clk);
    mem_en[d] = 1'b1;
    memwe[d]  = we;
    mar[d]    = a;
    mdr[d]    = wd;
    if (push) begin
      e.rd    = !we;
      e.exp   = exp;
      e.lat   = (d == 0) ? 1 : 4;
      e.issue = cyc;
      e.name  = name;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      pend[d]++;
    end
    @(negedge clk);
    mem_en[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input string name);
    int n = 0;
    while (done_cnt[d] < pend[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt[d] < pend[d]) begin
      vectors++;
      misc++;
      $display("FAIL %s_timeout: got no mem_r, want mem_r", name);
      done_cnt[d] = pend[d];
    end
  endtask

  task automatic acc(input int d, input bit we, input logic [15:0] a,
                     input logic [15:0] wd, input logic [15:0] exp,
                     input string name);
    issue(d, we, a, wd, exp, 1'b1, name);
    wait_done(d, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      mar[d] = '0;
      mdr[d] = '0;
      kb_data[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_memOut", memOut[d], 16'h0000);
      chk("rst_mem_r", 16'(mem_r[d]), 16'h0);
      chk("rst_disp_valid", 16'(disp_valid[d]), 16'h0);
      chk("rst_disp_data", 16'(disp_data[d]), 16'h0);
      chk("rst_kb_ready", 16'(kb_ready[d]), 16'h1);
      chk("rst_mcr_run", 16'(mcr_run[d]), 16'h1);
    end
    reset = 1'b1;

    acc(0, 1'b1, 16'h3000, 16'h1234, 16'h0, "w0_wr3000");
    acc(0, 1'b0, 16'h3000, 16'h0, 16'h1234, "w0_rd3000");
    chk("w0_memout_hold", memOut[0], 16'h1234);
    acc(0, 1'b1, 16'h3001, 16'h0F0F, 16'h0, "w0_wr3001");
    chk("w0_write_keeps_memout", memOut[0], 16'h1234);

    acc(1, 1'b1, 16'h3001, 16'hABCD, 16'h0, "w3_wr3001");
    issue(1, 1'b0, 16'h3001, 16'h0, 16'hABCD, 1'b1, "w3_rd3001");
    mem_en[1] = 1'b1;
    mar[1]    = 16'h3001;
    memwe[1]  = 1'b1;
    mdr[1]    = 16'hDEAD;
    @(negedge clk);
    mem_en[1] = 1'b0;
    wait_done(1, "w3_rd3001");
    repeat (8) @(negedge clk);
    acc(1, 1'b0, 16'h3001, 16'h0, 16'hABCD, "w3_dup_ignored");

    @(negedge clk);
    kb_valid[0] = 1'b1;
    kb_data[0]  = 8'h41;
    @(negedge clk);
    kb_valid[0] = 1'b0;
    chk("kb_ready_low", 16'(kb_ready[0]), 16'h0);
    acc(0, 1'b0, KBSR_ADDR, 16'h0, 16'h8000, "kbsr_full");
    acc(0, 1'b1, KBDR_ADDR, 16'h0099, 16'h0, "kbdr_wr_ignored");
    acc(0, 1'b0, KBDR_ADDR, 16'h0, 16'h0041, "kbdr_rd");
    acc(0, 1'b0, KBSR_ADDR, 16'h0, 16'h0000, "kbsr_clear");
    chk("kb_ready_high", 16'(kb_ready[0]), 16'h1);

    acc(0, 1'b1, DDR_ADDR, 16'h0048, 16'h0, "ddr_wr");
    chk("disp_valid_set", 16'(disp_valid[0]), 16'h1);
    chk("disp_data", 16'(disp_data[0]), 16'h0048);
    acc(0, 1'b0, DSR_ADDR, 16'h0, 16'h0000, "dsr_busy");
    acc(0, 1'b1, DDR_ADDR, 16'h0055, 16'h0, "ddr_wr_drop");
    chk("disp_data_kept", 16'(disp_data[0]), 16'h0048);
    acc(0, 1'b0, DDR_ADDR, 16'h0, 16'h0048, "ddr_rd");
    disp_ready[0] = 1'b1;
    @(negedge clk);
    disp_ready[0] = 1'b0;
    chk("disp_valid_clr", 16'(disp_valid[0]), 16'h0);
    acc(0, 1'b0, DSR_ADDR, 16'h0, 16'h8000, "dsr_ready");

    acc(0, 1'b1, MCR_ADDR, 16'h0000, 16'h0, "mcr_wr0");
    chk("mcr_run_off", 16'(mcr_run[0]), 16'h0);
    acc(0, 1'b0, MCR_ADDR, 16'h0, 16'h0000, "mcr_rd0");
    acc(0, 1'b1, 16'hFE10, 16'h7777, 16'h0, "hole_wr");
    acc(0, 1'b0, 16'hFE10, 16'h0, 16'h0000, "hole_rd");
    acc(0, 1'b1, MCR_ADDR, 16'h8001, 16'h0, "mcr_wr1");
    acc(0, 1'b0, MCR_ADDR, 16'h0, 16'h8001, "mcr_rd1");
    chk("mcr_run_on", 16'(mcr_run[0]), 16'h1);

    acc(1, 1'b1, 16'h3002, 16'h1111, 16'h0, "w3_wr3002");
    acc(1, 1'b0, 16'h3001, 16'h0, 16'hABCD, "w3_rd_pre_rst");
    issue(1, 1'b1, 16'h3002, 16'h5555, 16'h0, 1'b0, "w3_aborted");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_memOut", memOut[1], 16'h0000);
    chk("abort_mem_r", 16'(mem_r[1]), 16'h0);
    chk("abort_disp_valid", 16'(disp_valid[1]), 16'h0);
    chk("abort_kb_ready", 16'(kb_ready[1]), 16'h1);
    chk("abort_mcr_run", 16'(mcr_run[1]), 16'h1);
    chk("abort_memOut0", memOut[0], 16'h0000);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    acc(1, 1'b0, 16'h3002, 16'h0, 16'h1111, "w3_rd3002_kept");
    acc(0, 1'b0, 16'h3000, 16'h0, 16'h1234, "w0_ram_kept");

    repeat (4) @(negedge clk);
    chk("q0_empty", 16'(q0.size()), 16'h0);
    chk("q1_empty", 16'(q1.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
